// File: rtl/apb_sample_fetcher_if.sv
// APB requester/completer signal bundle for the sample fetcher.
//   master : drives PSEL, PENABLE, PWRITE, PADDR, PWDATA; receives PRDATA, PREADY, PSLVERR
//   slave  : the completer view of the same signals
interface apb_sample_fetcher_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [15:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_sample_fetcher.sv
// APB sample fetcher: on each rising edge of irq, performs one APB read from SAMPLE_ADDR and
// pushes PRDATA[11:0] into a first-word-fall-through FIFO.
//
// Ports:
//   sysclk        single clock, rising edge
//   reset         synchronous active-high reset
//   irq           sample-ready interrupt (rising edge triggers a read)
//   apb           APB requester (master modport of apb_sample_fetcher_if)
//   sample_data   FIFO head, 0 when empty
//   sample_valid  FIFO non-empty
//   sample_ready  consumer pop
//   fifo_count    FIFO occupancy
//   overflow      sticky: lost trigger or dropped sample
//   bus_err       sticky: PSLVERR response (or ACCESS timeout when enabled)
//   clr_flags     clears overflow and bus_err, wins over a same-cycle set
//
// Build option: define FETCH_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT cycles
// without PREADY. Without it the requester waits in ACCESS indefinitely.
module apb_sample_fetcher #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [11:0] SAMPLE_ADDR = 12'h000,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     irq,
  apb_sample_fetcher_if.master     apb,
  output logic [11:0]              sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     bus_err,
  input  logic                     clr_flags
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..256");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             irq_d_q, irq_d_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             bus_err_q, bus_err_d;
  logic [11:0]      mem_q [DEPTH];
  logic [11:0]      mem_d [DEPTH];

  logic trigger;
  logic timeout;
  logic ovf_trig;
  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic ovf_full;
  logic err_rsp;

  // Only the low 12 bits of PRDATA carry the sample.
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^apb.PRDATA[15:12];

  assign trigger = irq & ~irq_d_q;
  assign irq_d_d = irq;

  // APB requester outputs follow the registered state.
  assign apb.PSEL    = (state_q != StIdle);
  assign apb.PENABLE = (state_q == StAccess);
  assign apb.PWRITE  = 1'b0;
  assign apb.PADDR   = SAMPLE_ADDR;
  assign apb.PWDATA  = 32'h0;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive ACCESS cycles without PREADY; fires on the TIMEOUT-th one.
  always_comb begin
    tmo_cnt_d = '0;
    timeout   = 1'b0;
    if (state_q == StAccess && !apb.PREADY) begin
      if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
        timeout = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Transfer FSM and single-deep trigger pending slot.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ovf_trig  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger || pending_q) begin
          state_d   = StSetup;
          // Pending is consumed on SETUP entry; a fresh edge alongside it re-arms the slot.
          pending_d = trigger & pending_q;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (apb.PREADY || timeout) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (state_q != StIdle && trigger) begin
      if (pending_q) begin
        ovf_trig = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // FIFO control.
  assign sample_valid = (count_q != '0);
  assign full         = (count_q == CntW'(DEPTH));
  assign pop          = sample_valid & sample_ready;
  assign push_req     = (state_q == StAccess) & apb.PREADY & ~apb.PSLVERR;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push         = push_req & (~full | pop);
  assign ovf_full     = push_req & full & ~pop;
  assign err_rsp      = ((state_q == StAccess) & apb.PREADY & apb.PSLVERR) | timeout;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = apb.PRDATA[11:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = clr_flags ? 1'b0 : (overflow_q | ovf_trig | ovf_full);
    bus_err_d  = clr_flags ? 1'b0 : (bus_err_q | err_rsp);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      irq_d_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_d_q    <= irq_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Storage needs no reset: empty entries are masked at the output.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign sample_data = sample_valid ? mem_q[rd_ptr_q] : 12'h000;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_apb_sample_fetcher.sv
// Self-checking bench for apb_sample_fetcher: directed APB completer stimulus, expected samples
// queued at issue time and compared by a separate monitor on every pop.
`timescale 1ns/1ps
module tb_apb_sample_fetcher;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 15;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        irq;
  logic        sample_ready;
  logic        clr_flags;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  apb_sample_fetcher_if apb ();

  apb_sample_fetcher #(
    .DEPTH       (DEPTH),
    .SAMPLE_ADDR (12'h3A4),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .irq          (irq),
    .apb          (apb),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .bus_err      (bus_err),
    .clr_flags    (clr_flags)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs read 2ns after the rising edge.
  task automatic step();
    @(posedge sysclk);
    #2;
  endtask

  // Monitor: every pop is checked against the scoreboard head.
  always @(negedge sysclk) begin
    if (!reset && sample_valid && sample_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected no sample", sample_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        n_chk--;
        chk("pop_data", {20'h0, sample_data}, {20'h0, e});
      end
    end
  end

  // One full read: irq edge, SETUP, ACCESS with PREADY, back to IDLE.
  task automatic apb_read(input logic [15:0] data, input logic err, input logic pop_same,
                          input logic clr_same, input logic expect_push);
    irq = 1'b1;
    step();
    irq = 1'b0;
    chk("setup_psel", apb.PSEL, 1);
    chk("setup_penable", apb.PENABLE, 0);
    step();
    chk("access_penable", apb.PENABLE, 1);
    apb.PREADY  = 1'b1;
    apb.PRDATA  = data;
    apb.PSLVERR = err;
    sample_ready = pop_same;
    clr_flags    = clr_same;
    if (expect_push) exp_q.push_back(data[11:0]);
    step();
    apb.PREADY   = 1'b0;
    apb.PSLVERR  = 1'b0;
    apb.PRDATA   = 16'h0;
    sample_ready = 1'b0;
    clr_flags    = 1'b0;
    chk("idle_psel", apb.PSEL, 0);
  endtask

  task automatic drain(input int n);
    sample_ready = 1'b1;
    repeat (n) step();
    sample_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    irq          = 1'b0;
    sample_ready = 1'b0;
    clr_flags    = 1'b0;
    apb.PREADY   = 1'b0;
    apb.PSLVERR  = 1'b0;
    apb.PRDATA   = 16'h0;
    #2;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("paddr", apb.PADDR, 12'h3A4);
    chk("pwrite", apb.PWRITE, 0);
    chk("pwdata", apb.PWDATA, 0);

    // Basic read: FABC -> ABC one cycle after ACCESS
    apb_read(16'hFABC, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_valid", sample_valid, 1);
    chk("basic_data", sample_data, 12'hABC);
    chk("basic_count", fifo_count, 1);
    drain(1);
    chk("basic_drained", fifo_count, 0);
    chk("basic_empty_valid", sample_valid, 0);

    // 17 reads into a 16-deep FIFO without pops: last sample dropped
    for (int i = 0; i < 17; i++) begin
      apb_read(16'h5100 + 16'(i * 3), 1'b0, 1'b0, 1'b0, i < 16);
    end
    chk("full_count", fifo_count, 16);
    chk("full_overflow", overflow, 1);
    chk("full_head", sample_data, 12'h100);
    clear_flags();
    chk("ovf_cleared", overflow, 0);

    // Push and pop together while full: accepted, count stays, no overflow
    apb_read(16'h7ABC, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("fullpop_count", fifo_count, 16);
    chk("fullpop_overflow", overflow, 0);
    drain(16);
    chk("fullpop_drained", fifo_count, 0);

    // Error response: no push, bus_err set, then cleared
    apb_read(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_count", fifo_count, 0);
    chk("err_bus_err", bus_err, 1);
    clear_flags();
    chk("err_cleared", bus_err, 0);
    // clr_flags in the same cycle as the error wins
    apb_read(16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_priority", bus_err, 0);

    // Second edge during ACCESS -> pending; third -> overflow
    irq = 1'b1;
    step();
    irq = 1'b0;
    step();
    chk("pend_access", apb.PENABLE, 1);
    irq = 1'b1;
    step();
    irq = 1'b0;
    step();
    irq = 1'b1;
    step();
    irq = 1'b0;
    chk("pend_third_ovf", overflow, 1);
    chk("pend_still_access", apb.PENABLE, 1);
    apb.PREADY = 1'b1;
    apb.PRDATA = 16'h0A11;
    exp_q.push_back(12'hA11);
    step();
    apb.PREADY = 1'b0;
    chk("pend_idle", apb.PSEL, 0);
    step();
    chk("pend_setup_psel", apb.PSEL, 1);
    chk("pend_setup_penable", apb.PENABLE, 0);
    step();
    chk("pend_access2", apb.PENABLE, 1);
    apb.PREADY = 1'b1;
    apb.PRDATA = 16'h0B22;
    exp_q.push_back(12'hB22);
    step();
    apb.PREADY = 1'b0;
    chk("pend_idle2", apb.PSEL, 0);
    chk("pend_count", fifo_count, 2);
    step();
    chk("pend_no_extra", apb.PSEL, 0);
    drain(2);
    clear_flags();

    // PREADY held low in ACCESS
    irq = 1'b1;
    step();
    irq = 1'b0;
    step();
    chk("stall_access", apb.PENABLE, 1);
`ifdef FETCH_TIMEOUT_EN
    repeat (TIMEOUT - 1) step();
    chk("tmo_last_access", apb.PENABLE, 1);
    step();
    chk("tmo_idle", apb.PSEL, 0);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_count", fifo_count, 0);
    clear_flags();
`else
    repeat (1000) step();
    chk("stall_psel", apb.PSEL, 1);
    chk("stall_penable", apb.PENABLE, 1);
    chk("stall_bus_err", bus_err, 0);
    apb.PREADY = 1'b1;
    apb.PRDATA = 16'hC0DE;
    exp_q.push_back(12'h0DE);
    step();
    apb.PREADY = 1'b0;
    chk("stall_count", fifo_count, 1);
    drain(1);
`endif

    // Reset mid-ACCESS with PREADY, irq held high through reset
    irq = 1'b1;
    step();
    step();
    chk("mid_access", apb.PENABLE, 1);
    reset      = 1'b1;
    apb.PREADY = 1'b1;
    apb.PRDATA = 16'h0777;
    step();
    reset      = 1'b0;
    apb.PREADY = 1'b0;
    chk("midrst_psel", apb.PSEL, 0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", sample_valid, 0);
    step();
    chk("irqhold_setup_psel", apb.PSEL, 1);
    chk("irqhold_setup_penable", apb.PENABLE, 0);
    irq = 1'b0;
    step();
    apb.PREADY = 1'b1;
    apb.PRDATA = 16'h0456;
    exp_q.push_back(12'h456);
    step();
    apb.PREADY = 1'b0;
    chk("irqhold_count", fifo_count, 1);
    chk("irqhold_data", sample_data, 12'h456);
    drain(1);

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
